// File: rtl/l2_bus_pkg.sv
// Shared encodings for the L2 downstream bus interface: bus ops, snoop results, FSM states.
package l2_bus_pkg;

    typedef enum logic [1:0] {
        READ       = 2'd0,
        WRITE      = 2'd1,
        INVALIDATE = 2'd2,
        RFO        = 2'd3
    } bus_op_e;

    typedef enum logic [1:0] {
        NOHIT = 2'd0,
        HIT   = 2'd1,
        HITM  = 2'd2
    } snoop_e;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        SNOOP,
        DATA,
        DONE
    } state_e;

    // Encoding 3 on the snoop lines is reported as HITM.
    function automatic logic [1:0] norm_snoop(input logic [1:0] s);
        return (s == 2'd3) ? HITM : s;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/l2_bus_fifo.sv
// Synchronous FIFO, registered count; read data is the head entry, visible combinationally.
// Push is dropped when full, pop is dropped when empty; a pop never frees a slot in the same cycle.
module l2_bus_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign dout    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/l2_bus_if.sv
// L2 downstream bus unit: queues line ops, runs address/snoop/data phases, retries HITM reads/RFOs.
// Optional per-op completion counters under L2_BUS_STATS_EN; req_ready = !full, rsp has no back-pressure.
module l2_bus_if
    import l2_bus_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int OFFSET_W   = 6,
    parameter int FIFO_DEPTH = 4,
    parameter int SNOOP_WAIT = 2,
    parameter int LINE_BEATS = 4,
    parameter int MAX_RETRY  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              bus_req,
    input  logic              bus_gnt,
    output logic [1:0]        bus_op,
    output logic [ADDR_W-1:0] bus_addr,
    input  logic [1:0]        bus_snoop,
    input  logic              bus_data_rdy,
    output logic              rsp_valid,
    output logic [1:0]        rsp_op,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [1:0]        rsp_snoop,
    output logic              rsp_err,
    output logic [15:0]       stat_rd,
    output logic [15:0]       stat_wr,
    output logic [15:0]       stat_rfo,
    output logic [15:0]       stat_inv
);

    localparam int RTY_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int WAIT_W = $clog2(SNOOP_WAIT + 1);
    localparam int BEAT_W = $clog2(LINE_BEATS + 1);
    localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] LINE_MASK = {ADDR_W{1'b1}} << OFFSET_W;

    typedef struct packed {
        bus_op_e           op;
        logic [ADDR_W-1:0] addr;
    } req_ent_t;

    state_e            state_q, state_d;
    req_ent_t          fifo_din, fifo_dout;
    logic              fifo_full, fifo_empty, fifo_pop;
    logic [FCNT_W-1:0] fifo_count;

    bus_op_e           work_op;
    logic [ADDR_W-1:0] work_addr;
    logic [RTY_W-1:0]  retry_q;
    logic [WAIT_W-1:0] wait_q;
    logic [BEAT_W-1:0] beat_q;
    logic [1:0]        snoop_q;
    logic              err_q;

    logic [1:0]        snoop_now;
    logic              snoop_last, retryable, hitm, at_limit, last_beat;

    assign fifo_din.op   = bus_op_e'(req_op);
    assign fifo_din.addr = req_addr & LINE_MASK;
    assign req_ready     = !fifo_full;

    l2_bus_fifo #(
        .WIDTH ($bits(req_ent_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (req_valid && req_ready),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign snoop_now  = norm_snoop(bus_snoop);
    assign snoop_last = (state_q == SNOOP) && (wait_q == WAIT_W'(1));
    assign retryable  = (work_op == READ) || (work_op == RFO);
    assign hitm       = (snoop_now == HITM);
    assign at_limit   = (retry_q == RTY_W'(MAX_RETRY));
    assign last_beat  = bus_data_rdy && (beat_q == BEAT_W'(LINE_BEATS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (!fifo_empty) state_d = ADDR;
            ADDR:  if (bus_gnt) state_d = SNOOP;
            SNOOP: if (snoop_last) begin
                if (retryable && hitm) state_d = at_limit ? DONE : ADDR;
                else if (work_op == INVALIDATE) state_d = DONE;
                else state_d = DATA;
            end
            DATA:  if (last_beat) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fifo_pop  = (state_q == IDLE) && !fifo_empty;
        bus_req   = (state_q == ADDR);
        bus_op    = work_op;
        bus_addr  = work_addr;
        rsp_valid = (state_q == DONE);
        rsp_op    = work_op;
        rsp_addr  = work_addr;
        rsp_snoop = snoop_q;
        rsp_err   = err_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work_op   <= READ;
            work_addr <= '0;
            retry_q   <= '0;
            wait_q    <= '0;
            beat_q    <= '0;
            snoop_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            if (fifo_pop) begin
                work_op   <= fifo_dout.op;
                work_addr <= fifo_dout.addr;
                retry_q   <= '0;
                err_q     <= 1'b0;
            end
            if (state_q == ADDR && bus_gnt) wait_q <= WAIT_W'(SNOOP_WAIT);
            if (state_q == SNOOP) begin
                wait_q <= wait_q - WAIT_W'(1);
                if (snoop_last) begin
                    snoop_q <= snoop_now;
                    beat_q  <= '0;
                    if (retryable && hitm) begin
                        if (at_limit) err_q   <= 1'b1;
                        else          retry_q <= retry_q + RTY_W'(1);
                    end
                end
            end
            if (state_q == DATA && bus_data_rdy) beat_q <= beat_q + BEAT_W'(1);
        end
    end

    full_tracks_count: assert property (@(posedge clk) disable iff (rst)
        fifo_full == (fifo_count == FCNT_W'(FIFO_DEPTH)));

`ifdef L2_BUS_STATS_EN
    logic [15:0] rd_q, wr_q, rfo_q, inv_q;

    // Only error-free completions are counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            rfo_q <= '0;
            inv_q <= '0;
        end else if (state_q == DONE && !err_q) begin
            case (work_op)
                READ:       rd_q  <= sat_inc(rd_q);
                WRITE:      wr_q  <= sat_inc(wr_q);
                RFO:        rfo_q <= sat_inc(rfo_q);
                INVALIDATE: inv_q <= sat_inc(inv_q);
                default:    rd_q  <= rd_q;
            endcase
        end
    end

    assign stat_rd  = rd_q;
    assign stat_wr  = wr_q;
    assign stat_rfo = rfo_q;
    assign stat_inv = inv_q;
`else
    assign stat_rd  = '0;
    assign stat_wr  = '0;
    assign stat_rfo = '0;
    assign stat_inv = '0;
`endif

endmodule

// File: tb/tb_l2_bus_if.sv
// Directed bench for l2_bus_if: latency, retry, error, invalidate, queue-full and reset-abort scenarios.
module tb_l2_bus_if;

`ifdef L2_BUS_STATS_EN
    localparam int STAT_ON = 1;
`else
    localparam int STAT_ON = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'd0;
    logic [31:0] req_addr = '0;
    logic        bus_req;
    logic        bus_gnt = 1'b1;
    logic [1:0]  bus_op;
    logic [31:0] bus_addr;
    logic [1:0]  bus_snoop;
    logic        bus_data_rdy = 1'b1;
    logic        rsp_valid;
    logic [1:0]  rsp_op;
    logic [31:0] rsp_addr;
    logic [1:0]  rsp_snoop;
    logic        rsp_err;
    logic [15:0] stat_rd, stat_wr, stat_rfo, stat_inv;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    l2_bus_if dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_addr     (req_addr),
        .bus_req      (bus_req),
        .bus_gnt      (bus_gnt),
        .bus_op       (bus_op),
        .bus_addr     (bus_addr),
        .bus_snoop    (bus_snoop),
        .bus_data_rdy (bus_data_rdy),
        .rsp_valid    (rsp_valid),
        .rsp_op       (rsp_op),
        .rsp_addr     (rsp_addr),
        .rsp_snoop    (rsp_snoop),
        .rsp_err      (rsp_err),
        .stat_rd      (stat_rd),
        .stat_wr      (stat_wr),
        .stat_rfo     (stat_rfo),
        .stat_inv     (stat_inv)
    );

    // Monitor: counts address phases and records completions at each rising edge.
    int          rises = 0;
    int          cyc = 0;
    int          rsp_cnt = 0;
    logic        req_prev = 1'b0;
    logic [31:0] rsp_addr_q[$];
    logic [1:0]  rsp_op_q[$];
    int          rsp_cyc_q[$];

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            req_prev = 1'b0;
        end else begin
            if (bus_req && !req_prev) rises = rises + 1;
            req_prev = bus_req;
            if (rsp_valid) begin
                rsp_addr_q.push_back(rsp_addr);
                rsp_op_q.push_back(rsp_op);
                rsp_cyc_q.push_back(cyc);
                rsp_cnt = rsp_cnt + 1;
            end
        end
    end

    // Snoop responder: plan[k] answers the (k+1)-th address phase since plan_base.
    logic [1:0] plan [8];
    int         plan_base = 0;
    int         snoop_idx;

    always_comb begin
        snoop_idx = rises - plan_base;
        bus_snoop = 2'd0;
        if (snoop_idx >= 1 && snoop_idx <= 8) bus_snoop = plan[snoop_idx-1];
    end

    task automatic push1(input logic [1:0] op, input logic [31:0] addr);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Cycles counted inclusively from the pop cycle up to the cycle rsp_valid is seen.
    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus_req, bus_op, bus_addr, rsp_valid, rsp_op, rsp_addr, rsp_snoop, rsp_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %0h expected 0",
                     {bus_req, bus_op, bus_addr, rsp_valid, rsp_op, rsp_addr, rsp_snoop, rsp_err});
        end
        checks++;
        if ({stat_rd, stat_wr, stat_rfo, stat_inv} !== 64'd0) begin
            errors++;
            $display("FAIL reset_stats: got %0h expected 0", {stat_rd, stat_wr, stat_rfo, stat_inv});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %0b expected 1", req_ready);
        end
    endtask

    task automatic test_read;
        int lat;
        plan[0] = 2'd0;
        plan_base = rises;
        push1(2'd0, 32'h0000_1234);
        wait_rsp(lat);
        checks++;
        if (lat !== 9) begin errors++; $display("FAIL read_latency: got %0d expected 9", lat); end
        checks++;
        if ({rsp_op, rsp_snoop, rsp_err} !== 5'b0) begin
            errors++; $display("FAIL read_rsp_fields: got %0h expected 0", {rsp_op, rsp_snoop, rsp_err});
        end
        checks++;
        if (rsp_addr !== 32'h0000_1200) begin
            errors++; $display("FAIL read_rsp_addr: got %0h expected 1200", rsp_addr);
        end
        checks++;
        if (bus_addr !== 32'h0000_1200) begin
            errors++; $display("FAIL read_bus_addr: got %0h expected 1200", bus_addr);
        end
        checks++;
        if (rises - plan_base !== 1) begin
            errors++; $display("FAIL read_addr_phases: got %0d expected 1", rises - plan_base);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL read_rsp_pulse: got %0b expected 0", rsp_valid); end
        checks++;
        if (stat_rd !== 16'(STAT_ON)) begin
            errors++; $display("FAIL read_stat: got %0d expected %0d", stat_rd, STAT_ON);
        end
    endtask

    task automatic test_rfo_retry;
        int lat;
        plan[0] = 2'd2; plan[1] = 2'd2; plan[2] = 2'd1;
        plan_base = rises;
        push1(2'd3, 32'h0000_0040);
        wait_rsp(lat);
        checks++;
        if (lat !== 15) begin errors++; $display("FAIL rfo_latency: got %0d expected 15", lat); end
        checks++;
        if (rises - plan_base !== 3) begin
            errors++; $display("FAIL rfo_addr_phases: got %0d expected 3", rises - plan_base);
        end
        checks++;
        if ({rsp_op, rsp_snoop, rsp_err, rsp_addr} !== {2'd3, 2'd1, 1'b0, 32'h40}) begin
            errors++; $display("FAIL rfo_rsp: got %0h expected %0h",
                               {rsp_op, rsp_snoop, rsp_err, rsp_addr}, {2'd3, 2'd1, 1'b0, 32'h40});
        end
        @(negedge clk);
        checks++;
        if (stat_rfo !== 16'(STAT_ON)) begin
            errors++; $display("FAIL rfo_stat: got %0d expected %0d", stat_rfo, STAT_ON);
        end
    endtask

    task automatic test_read_err;
        int lat;
        plan[0] = 2'd2; plan[1] = 2'd3; plan[2] = 2'd2; plan[3] = 2'd3;
        plan_base = rises;
        push1(2'd0, 32'h2000_00C5);
        wait_rsp(lat);
        checks++;
        if (lat !== 14) begin errors++; $display("FAIL err_latency: got %0d expected 14", lat); end
        checks++;
        if (rises - plan_base !== 4) begin
            errors++; $display("FAIL err_addr_phases: got %0d expected 4", rises - plan_base);
        end
        checks++;
        if ({rsp_op, rsp_snoop, rsp_err, rsp_addr} !== {2'd0, 2'd2, 1'b1, 32'h2000_00C0}) begin
            errors++; $display("FAIL err_rsp: got %0h expected %0h",
                               {rsp_op, rsp_snoop, rsp_err, rsp_addr}, {2'd0, 2'd2, 1'b1, 32'h2000_00C0});
        end
        @(negedge clk);
        checks++;
        if (stat_rd !== 16'(STAT_ON)) begin
            errors++; $display("FAIL err_stat_unchanged: got %0d expected %0d", stat_rd, STAT_ON);
        end
    endtask

    task automatic test_invalidate;
        int lat;
        bus_data_rdy = 1'b0;
        plan[0] = 2'd2;
        plan_base = rises;
        push1(2'd2, 32'h0000_0080);
        wait_rsp(lat);
        checks++;
        if (lat !== 5) begin errors++; $display("FAIL inv_latency: got %0d expected 5", lat); end
        checks++;
        if (rises - plan_base !== 1) begin
            errors++; $display("FAIL inv_addr_phases: got %0d expected 1", rises - plan_base);
        end
        checks++;
        if ({rsp_op, rsp_snoop, rsp_err, rsp_addr} !== {2'd2, 2'd2, 1'b0, 32'h80}) begin
            errors++; $display("FAIL inv_rsp: got %0h expected %0h",
                               {rsp_op, rsp_snoop, rsp_err, rsp_addr}, {2'd2, 2'd2, 1'b0, 32'h80});
        end
        @(negedge clk);
        checks++;
        if (stat_inv !== 16'(STAT_ON)) begin
            errors++; $display("FAIL inv_stat: got %0d expected %0d", stat_inv, STAT_ON);
        end
        bus_data_rdy = 1'b1;
    endtask

    task automatic test_back_to_back;
        int base;
        int n;
        for (int k = 0; k < 8; k++) plan[k] = 2'd0;
        plan_base = rises;
        base = rsp_cnt;
        bus_gnt = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            req_valid = 1'b1;
            req_op    = 2'd1;
            req_addr  = 32'h1000 + 32'(k) * 32'h100;
        end
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready: got %0b expected 0", req_ready); end
        // A sixth write held while full must be ignored.
        req_addr = 32'h0000_F000;
        repeat (3) @(negedge clk);
        req_valid = 1'b0;
        bus_gnt = 1'b1;
        n = 0;
        while (rsp_cnt - base < 5 && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (20) @(negedge clk);
        checks++;
        if (rsp_cnt - base !== 5) begin
            errors++; $display("FAIL b2b_rsp_count: got %0d expected 5", rsp_cnt - base);
        end
        if (rsp_cnt - base >= 5) begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if ({rsp_op_q[base+i], rsp_addr_q[base+i]} !== {2'd1, 32'h1000 + 32'(i) * 32'h100}) begin
                    errors++; $display("FAIL b2b_order[%0d]: got %0h expected %0h", i,
                                       {rsp_op_q[base+i], rsp_addr_q[base+i]},
                                       {2'd1, 32'h1000 + 32'(i) * 32'h100});
                end
            end
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (rsp_cyc_q[base+i+1] - rsp_cyc_q[base+i] !== 9) begin
                    errors++; $display("FAIL b2b_spacing[%0d]: got %0d expected 9", i,
                                       rsp_cyc_q[base+i+1] - rsp_cyc_q[base+i]);
                end
            end
        end
        checks++;
        if (stat_wr !== 16'(5 * STAT_ON)) begin
            errors++; $display("FAIL b2b_stat_wr: got %0d expected %0d", stat_wr, 5 * STAT_ON);
        end
    endtask

    task automatic test_reset_mid;
        int lat;
        int base;
        plan[0] = 2'd0;
        plan_base = rises;
        base = rsp_cnt;
        push1(2'd0, 32'h0000_3000);
        // Two beats complete in the first two DATA cycles, then the bus stalls.
        repeat (6) @(negedge clk);
        bus_data_rdy = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({bus_req, bus_op, bus_addr, rsp_valid, rsp_op, rsp_addr, rsp_snoop, rsp_err} !== '0) begin
            errors++;
            $display("FAIL midrst_outputs: got %0h expected 0",
                     {bus_req, bus_op, bus_addr, rsp_valid, rsp_op, rsp_addr, rsp_snoop, rsp_err});
        end
        checks++;
        if ({stat_rd, stat_wr, stat_rfo, stat_inv} !== 64'd0) begin
            errors++; $display("FAIL midrst_stats: got %0h expected 0", {stat_rd, stat_wr, stat_rfo, stat_inv});
        end
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %0b expected 1", req_ready); end
        @(negedge clk);
        rst = 1'b0;
        bus_data_rdy = 1'b1;
        repeat (15) @(negedge clk);
        checks++;
        if (rsp_cnt !== base) begin
            errors++; $display("FAIL midrst_no_rsp: got %0d expected %0d", rsp_cnt, base);
        end
        plan_base = rises;
        push1(2'd0, 32'h0000_4000);
        wait_rsp(lat);
        checks++;
        if (lat !== 9) begin errors++; $display("FAIL midrst_next_latency: got %0d expected 9", lat); end
        checks++;
        if (rsp_addr !== 32'h0000_4000) begin
            errors++; $display("FAIL midrst_next_addr: got %0h expected 4000", rsp_addr);
        end
        @(negedge clk);
        checks++;
        if (stat_rd !== 16'(STAT_ON)) begin
            errors++; $display("FAIL midrst_next_stat: got %0d expected %0d", stat_rd, STAT_ON);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_rfo_retry();
        test_read_err();
        test_invalidate();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
